// File: rtl/waveform_sequencer.sv
// waveform_sequencer
//   Hands a single DAC/PWM output path between up to seven waveform
//   generators. A switch drains the running generator until its sample
//   reaches zero (or a timeout expires), then holds every generator off
//   for a fixed dead time before the next one is enabled. An optional
//   auto-scan steps through the waves after a fixed dwell time.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   OFF    | no generator enabled, outputs zero, waiting for a wave request
//   RUN    | generator active_sel enabled and routed to dac_out/pwm_out
//   DRAIN  | old generator still enabled, waiting for a zero sample/timeout
//   SETTLE | all generators off for SETTLE_CYCLES, then RUN target or OFF
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   req_valid/req_sel    mode change request (req_sel >= NUM_WAVES = stop)
//   req_ready            request accepted when req_valid && req_ready
//   auto_scan            step through the waves every DWELL_CYCLES in RUN
//   sample_in, pwm_in    packed generator DAC codes and PWM outputs
//   gen_enable           one-hot or all-zero generator enables
//   active_sel           current or last wave index
//   dac_out, pwm_out     registered selected sample / PWM
//   busy                 high in DRAIN or SETTLE
//   switch_done          one-cycle pulse on entering RUN with a new wave
module waveform_sequencer #(
  parameter int WIDTH         = 8,
  parameter int NUM_WAVES     = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int DRAIN_TIMEOUT = 1_000_000,
  parameter int DWELL_CYCLES  = 100_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [2:0]                 req_sel,
  output logic                       req_ready,
  input  logic                       auto_scan,
  input  logic [NUM_WAVES*WIDTH-1:0] sample_in,
  input  logic [NUM_WAVES-1:0]       pwm_in,
  output logic [NUM_WAVES-1:0]       gen_enable,
  output logic [2:0]                 active_sel,
  output logic [WIDTH-1:0]           dac_out,
  output logic                       pwm_out,
  output logic                       busy,
  output logic                       switch_done
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DRAIN_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int DWELL_W  = (DWELL_CYCLES > 1)  ? $clog2(DWELL_CYCLES)  : 1;

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LOAD  = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]          LAST_WAVE   = 3'(NUM_WAVES - 1);
  localparam logic [2:0]          WAVE_LIMIT  = 3'(NUM_WAVES);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_target;
  logic [2:0]          r_active;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic [WIDTH-1:0]    r_dac;
  logic                r_pwm;
  logic                r_switch_done;

  state_t              w_state_nxt;
  logic [2:0]          w_target_nxt;
  logic [2:0]          w_active_nxt;
  logic                w_switch;
  logic                w_ready;
  logic                w_accept;
  logic                w_req_stop;
  logic                w_target_stop;
  logic                w_dwell_hit;
  logic [2:0]          w_auto_sel;
  logic [WIDTH-1:0]    w_cur_sample;
  logic                w_cur_zero;
  logic [WIDTH-1:0]    w_nxt_sample;
  logic                w_nxt_pwm;
  logic                w_route_nxt;

  assign w_ready       = !reset && (r_state == ST_OFF || r_state == ST_RUN);
  assign w_accept      = req_valid && w_ready;
  assign w_req_stop    = (req_sel >= WAVE_LIMIT);
  assign w_target_stop = (r_target >= WAVE_LIMIT);
  assign w_dwell_hit   = (r_state == ST_RUN) && auto_scan && (r_dwell_cnt == DWELL_LAST);
  // With a single wave this wraps to the current wave, so no switch happens.
  assign w_auto_sel    = (r_active == LAST_WAVE) ? 3'd0 : r_active + 3'd1;

  // Sample of the wave currently enabled, used to detect the drain point.
  always_comb begin
    w_cur_sample = '0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      if (r_active == 3'(i)) begin
        w_cur_sample = sample_in[i*WIDTH +: WIDTH];
      end
    end
  end
  assign w_cur_zero = (w_cur_sample == '0);

  // Output registers are loaded from the wave that will be active next
  // cycle, so the first RUN cycle already shows the new wave's sample.
  always_comb begin
    w_nxt_sample = '0;
    w_nxt_pwm    = 1'b0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      if (w_active_nxt == 3'(i)) begin
        w_nxt_sample = sample_in[i*WIDTH +: WIDTH];
        w_nxt_pwm    = pwm_in[i];
      end
    end
  end
  assign w_route_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_active_nxt = r_active;
    w_switch     = 1'b0;
    case (r_state)
      ST_OFF: begin
        // A stop request while already off is consumed without effect.
        if (w_accept && !w_req_stop) begin
          w_target_nxt = req_sel;
          w_state_nxt  = ST_SETTLE;
        end
      end
      ST_RUN: begin
        // The external request takes priority over a dwell expiry.
        if (w_accept) begin
          if (req_sel != r_active) begin
            w_target_nxt = req_sel;
            w_state_nxt  = ST_DRAIN;
          end
        end else if (w_dwell_hit && (w_auto_sel != r_active)) begin
          w_target_nxt = w_auto_sel;
          w_state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_cur_zero || (r_drain_cnt == '0)) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == '0) begin
          if (w_target_stop) begin
            w_state_nxt = ST_OFF;
          end else begin
            w_active_nxt = r_target;
            w_state_nxt  = ST_RUN;
            w_switch     = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_OFF;
      r_target      <= 3'd0;
      r_active      <= 3'd0;
      r_drain_cnt   <= '0;
      r_settle_cnt  <= '0;
      r_dwell_cnt   <= '0;
      r_dac         <= '0;
      r_pwm         <= 1'b0;
      r_switch_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_target      <= w_target_nxt;
      r_active      <= w_active_nxt;
      r_switch_done <= w_switch;

      if (w_state_nxt == ST_DRAIN && r_state != ST_DRAIN) begin
        r_drain_cnt <= DRAIN_LOAD;
      end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
      end

      if (w_state_nxt == ST_SETTLE && r_state != ST_SETTLE) begin
        r_settle_cnt <= SETTLE_LOAD;
      end else if (r_state == ST_SETTLE && r_settle_cnt != '0) begin
        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
      end

      // Restarts after every expiry and every accepted request, and holds
      // at zero outside RUN or while auto-scan is off.
      if (r_state == ST_RUN && w_state_nxt == ST_RUN && auto_scan &&
          !w_accept && !w_dwell_hit) begin
        r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
      end else begin
        r_dwell_cnt <= '0;
      end

      if (w_route_nxt) begin
        r_dac <= w_nxt_sample;
        r_pwm <= w_nxt_pwm;
      end else begin
        r_dac <= '0;
        r_pwm <= 1'b0;
      end
    end
  end

  always_comb begin
    gen_enable = '0;
    if (!reset && (r_state == ST_RUN || r_state == ST_DRAIN)) begin
      for (int i = 0; i < NUM_WAVES; i++) begin
        gen_enable[i] = (r_active == 3'(i));
      end
    end
  end

  assign req_ready   = w_ready;
  assign busy        = !reset && (r_state == ST_DRAIN || r_state == ST_SETTLE);
  assign active_sel  = r_active;
  assign dac_out     = r_dac;
  assign pwm_out     = r_pwm;
  assign switch_done = r_switch_done;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer: requests push their expected outcome onto a
// scoreboard, which is popped and compared when the switch completes.
module tb_waveform_sequencer;

  localparam int WIDTH    = 8;
  localparam int NW       = 4;
  localparam int SETTLE   = 4;
  localparam int DRAIN_TO = 64;
  localparam int DWELL    = 10;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic [2:0]            req_sel;
  logic                  req_ready;
  logic                  auto_scan;
  logic [NW*WIDTH-1:0]   sample_in;
  logic [NW-1:0]         pwm_in;
  logic [NW-1:0]         gen_enable;
  logic [2:0]            active_sel;
  logic [WIDTH-1:0]      dac_out;
  logic                  pwm_out;
  logic                  busy;
  logic                  switch_done;

  logic [WIDTH-1:0]      samp [NW];

  assign sample_in = {samp[3], samp[2], samp[1], samp[0]};

  always #5 clk = ~clk;

  waveform_sequencer #(
    .WIDTH(WIDTH), .NUM_WAVES(NW), .SETTLE_CYCLES(SETTLE),
    .DRAIN_TIMEOUT(DRAIN_TO), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .auto_scan(auto_scan), .sample_in(sample_in),
    .pwm_in(pwm_in), .gen_enable(gen_enable), .active_sel(active_sel),
    .dac_out(dac_out), .pwm_out(pwm_out), .busy(busy), .switch_done(switch_done)
  );

  typedef struct {
    logic [2:0] sel;
    bit         stop;
    int         drain;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] dac;
    logic       pwm;
  } dexp_t;

  exp_t  sb [$];
  dexp_t dq [$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_switch(input logic [2:0] exp_sel, input bit stop, input int drain, input int lat);
    exp_t e;
    e.sel   = exp_sel;
    e.stop  = stop;
    e.drain = drain;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // Drive a request just after a rising edge and record what it should do.
  task automatic issue(input logic [2:0] sel, input logic [2:0] exp_sel, input bit stop, input int drain);
    req_valid = 1'b1;
    req_sel   = sel;
    expect_switch(exp_sel, stop, drain, 2 + drain + SETTLE);
  endtask

  task automatic await_switch(input bit ramp);
    exp_t       e;
    int         lat, n_drain, n_settle, n_ready_busy;
    bit         seen_busy, done, by_pulse;
    logic [3:0] oh;
    e = sb.pop_front();
    lat = 0; n_drain = 0; n_settle = 0; n_ready_busy = 0;
    seen_busy = 0; done = 0; by_pulse = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (busy) begin
        seen_busy = 1;
        if (gen_enable != '0) n_drain++;
        else n_settle++;
        if (req_ready) n_ready_busy++;
      end
      if (switch_done) begin
        done = 1;
        by_pulse = 1;
      end else if (seen_busy && !busy) begin
        done = 1;
      end
      if (!done) begin
        tick();
        req_valid = 1'b0;
        if (ramp) samp[2] = (samp[2] >= 8'd20) ? samp[2] - 8'd20 : 8'd0;
      end
    end
    req_valid = 1'b0;
    oh = e.stop ? 4'b0000 : (4'b0001 << e.sel);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("drain_cycles", 32'(n_drain), 32'(e.drain));
    chk("settle_cycles", 32'(n_settle), 32'(SETTLE));
    chk("ready_while_busy", 32'(n_ready_busy), 32'd0);
    chk("switch_pulse", 32'(by_pulse), 32'(!e.stop));
    chk("active_sel", 32'(active_sel), 32'(e.sel));
    chk("gen_enable", 32'(gen_enable), 32'(oh));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dexp_t d;
    int    nb, nsd, nge, nrdy;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_sel   = 3'd0;
    auto_scan = 1'b0;
    pwm_in    = '0;
    samp[0] = 8'h10; samp[1] = 8'h21; samp[2] = 8'h32; samp[3] = 8'h43;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_gen_enable", 32'(gen_enable), 32'd0);
    chk("rst_active_sel", 32'(active_sel), 32'd0);
    chk("rst_dac_out", 32'(dac_out), 32'd0);
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_switch_done", 32'(switch_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // OFF -> wave 2, then dac/pwm follow wave 2 one cycle late
    tick();
    issue(3'd2, 3'd2, 0, 0);
    await_switch(0);
    chk("dac_first_run", 32'(dac_out), 32'(samp[2]));
    for (int k = 0; k < 5; k++) begin
      d.dac = samp[2];
      d.pwm = pwm_in[2];
      dq.push_back(d);
      tick();
      samp[2]   = 8'h80 + 8'(k);
      pwm_in[2] = k[0];
      pwm_in[1] = ~k[0];
      @(negedge clk);
      d = dq.pop_front();
      chk("dac_follow", 32'(dac_out), 32'(d.dac));
      chk("pwm_follow", 32'(pwm_out), 32'(d.pwm));
    end

    // Same-wave request: accepted, nothing happens
    tick();
    req_valid = 1'b1;
    req_sel   = 3'd2;
    nb = 0; nsd = 0; nge = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (switch_done) nsd++;
      if (gen_enable != 4'b0100) nge++;
      tick();
      req_valid = 1'b0;
    end
    chk("same_wave_busy", 32'(nb), 32'd0);
    chk("same_wave_pulse", 32'(nsd), 32'd0);
    chk("same_wave_enable", 32'(nge), 32'd0);

    // Drain until the ramp on wave 2 hits zero: 200/20 cycles
    samp[2] = 8'd200;
    issue(3'd0, 3'd0, 0, 200 / 20);
    await_switch(1);

    // Drain timeout with wave 0 stuck at 0x55
    tick();
    samp[0] = 8'h55;
    issue(3'd1, 3'd1, 0, DRAIN_TO);
    await_switch(0);

    // Go to wave 3 (zero sample drains in one cycle), then auto-scan to 0
    tick();
    samp[1] = 8'h00;
    issue(3'd3, 3'd3, 0, 1);
    await_switch(0);
    tick();
    auto_scan = 1'b1;
    samp[3]   = 8'h00;
    expect_switch(3'd0, 0, 1, (DWELL - 1) + 2 + 1 + SETTLE);
    await_switch(0);
    tick();
    auto_scan = 1'b0;
    samp[0]   = 8'h00;

    // Back to wave 3, then an external request collides with dwell expiry
    tick();
    issue(3'd3, 3'd3, 0, 1);
    await_switch(0);
    tick();
    auto_scan = 1'b1;
    repeat (DWELL - 1) tick();
    issue(3'd1, 3'd1, 0, 1);
    await_switch(0);
    tick();
    auto_scan = 1'b0;

    // Reset in the middle of SETTLE abandons the pending wave
    tick();
    req_valid = 1'b1;
    req_sel   = 3'd2;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_settle_busy", 32'(busy), 32'd1);
    chk("mid_settle_enable", 32'(gen_enable), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst2_gen_enable", 32'(gen_enable), 32'd0);
    chk("rst2_active_sel", 32'(active_sel), 32'd0);
    chk("rst2_dac_out", 32'(dac_out), 32'd0);
    chk("rst2_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_req_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    nb = 0; nsd = 0; nge = 0; nrdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (switch_done) nsd++;
      if (gen_enable != '0) nge++;
      if (!req_ready) nrdy++;
      tick();
    end
    chk("post_rst_busy", 32'(nb), 32'd0);
    chk("post_rst_pulse", 32'(nsd), 32'd0);
    chk("post_rst_enable", 32'(nge), 32'd0);
    chk("post_rst_ready", 32'(nrdy), 32'd0);

    // Stop while already off is ignored
    req_valid = 1'b1;
    req_sel   = 3'd7;
    nb = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) nb++;
      tick();
      req_valid = 1'b0;
    end
    chk("off_stop_busy", 32'(nb), 32'd0);

    // Wave 1, then stop: drain, settle, OFF with last wave kept
    samp[1] = 8'h21;
    issue(3'd1, 3'd1, 0, 0);
    await_switch(0);
    tick();
    samp[1] = 8'h00;
    issue(3'd7, 3'd1, 1, 1);
    await_switch(0);
    chk("stop_dac_out", 32'(dac_out), 32'd0);
    chk("stop_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_sequencer.md
WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the sample/DAC code width.
REQ-002 SHALL have parameter NUM_WAVES, default 4 (legal 1..7), meaning the number of attached waveform generators.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16 (>=1), meaning the dead time with all generators disabled between waves.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 1_000_000 (>=1), meaning the maximum number of cycles spent waiting for a zero sample.
REQ-005 SHALL have parameter DWELL_CYCLES, default 100_000_000 (>=2), meaning the auto-scan time per wave.
REQ-006 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit: a mode change request is present.
REQ-009 SHALL have port req_sel, input, 3 bits: the requested wave; values 0..NUM_WAVES-1 select a wave, any other value means stop.
REQ-010 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-011 SHALL have port auto_scan, input, 1 bit: cycle through waves automatically.
REQ-012 SHALL have port sample_in, input, NUM_WAVES*WIDTH bits: packed generator DAC codes, with wave i at bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port pwm_in, input, NUM_WAVES bits: the generator PWM outputs.
REQ-014 SHALL have port gen_enable, output, NUM_WAVES bits: one-hot or all-zero generator enables.
REQ-015 SHALL have port active_sel, output, 3 bits: the index of the current or last wave.
REQ-016 SHALL have port dac_out, output, WIDTH bits: the registered selected DAC code.
REQ-017 SHALL have port pwm_out, output, 1 bit: the registered selected PWM.
REQ-018 SHALL have port busy, output, 1 bit: high in DRAIN or SETTLE.
REQ-019 SHALL have port switch_done, output, 1 bit: a one-cycle pulse on entering RUN with a new wave.

Function
REQ-020 SHALL implement the FSM states OFF, RUN, DRAIN and SETTLE; reset enters OFF.
REQ-021 SHALL drive req_ready high only in OFF or RUN, and accept a request on a cycle where req_valid and req_ready are both high.
REQ-022 OFF: an accepted wave request SHALL store the target and go to SETTLE; an accepted stop SHALL be accepted and ignored.
REQ-023 RUN: gen_enable SHALL equal one-hot(active_sel); an accepted request for a different wave or for stop SHALL store the target and go to DRAIN.
REQ-024 RUN: an accepted request equal to active_sel SHALL be accepted with no state change and no switch_done.
REQ-025 DRAIN: the generator SHALL stay enabled; on the first cycle where sample_in[active_sel] == 0, or after DRAIN_TIMEOUT cycles in DRAIN, the FSM SHALL go to SETTLE.
REQ-026 SETTLE: gen_enable SHALL be all zero for exactly SETTLE_CYCLES cycles.
REQ-027 At the end of SETTLE, the FSM SHALL go to RUN with active_sel = target and pulse switch_done for 1 cycle, or go to OFF if the target is stop (no pulse).
REQ-028 In OFF and SETTLE, dac_out and pwm_out SHALL be 0; in RUN and DRAIN, each SHALL equal the selected input delayed by 1 cycle.
REQ-029 Auto-scan: in RUN with auto_scan high, a dwell counter SHALL count cycles; after DWELL_CYCLES it SHALL raise an internal request to (active_sel+1) mod NUM_WAVES.
REQ-030 If the internal request and an external req_valid occur in the same cycle, the external request SHALL win and the dwell counter SHALL clear.
REQ-031 The dwell counter SHALL clear on leaving RUN and whenever auto_scan is low.
REQ-032 With NUM_WAVES = 1, the auto-scan target SHALL be the current wave, so no switch occurs.
REQ-033 Requests arriving while busy SHALL not be accepted (req_ready low); the requester SHALL hold req_valid and req_sel stable until accepted.
REQ-034 The DRAIN timeout counter and the SETTLE counter SHALL be sized by $clog2 of their parameters and SHALL reload on every state entry.

Reset
REQ-035 While reset is high: state OFF, gen_enable 0, active_sel 0, dac_out 0, pwm_out 0, busy 0, switch_done 0, req_ready 0, all counters 0.
REQ-036 req_ready SHALL be high on the first cycle after reset deasserts.
REQ-037 Reset asserted in any state, including mid-DRAIN or mid-SETTLE, SHALL abandon the pending target and return to OFF on the next edge.

Verification (bench parameters: WIDTH=8, NUM_WAVES=4, SETTLE_CYCLES=4, DRAIN_TIMEOUT=64, DWELL_CYCLES=10)
REQ-038 Reset, then request wave 2 -> 4 cycles with gen_enable=0000, then gen_enable=0100, one switch_done pulse, dac_out follows sample 2 one cycle later.
REQ-039 In RUN on wave 2 with sample 2 ramping from 200, request wave 0 -> gen_enable stays 0100 until sample 2 reads 0, then 4 cycles of 0000, then 0001; busy is high throughout.
REQ-040 In RUN, hold sample_in[active] at 0x55 and request wave 1 -> SETTLE is entered exactly 64 cycles after DRAIN entry.
REQ-041 auto_scan=1 on wave 3 -> wave 3 switches to wave 0 after 10 cycles in RUN; an external request for wave 1 issued on the dwell-expiry cycle wins, and the target becomes 1.
REQ-042 Assert reset during SETTLE, then request req_sel=7 while in RUN -> the first returns to OFF with all outputs 0; the second drains, settles, ends in OFF with no switch_done.
